// File: rtl/uart_fifo_tx_if.sv
// uart_fifo_tx_if: pop-side connection between a synchronous FIFO and its
// consumer. The master modport is the consumer: it drives fifoPop and
// observes fifoEmpty and fifoPopData. The slave modport is the FIFO itself.
interface uart_fifo_tx_if #(
  parameter int bitWidth = 8
) ();
  logic                fifoEmpty;
  logic [bitWidth-1:0] fifoPopData;
  logic                fifoPop;

  modport master (
    output fifoPop,
    input  fifoEmpty,
    input  fifoPopData
  );

  modport slave (
    input  fifoPop,
    output fifoEmpty,
    output fifoPopData
  );
endinterface

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: drains words from the pop side of a FIFO and sends each one
// as an asynchronous UART frame (start, bitWidth data bits LSB first,
// optional even parity, one stop bit) on txd.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// All outputs come straight from flops, so fifoEmpty and fifoPopData only
// reach the outputs through the state register. The next-state logic
// computes the output values for the coming cycle, which keeps the FSM and
// the outputs cycle-aligned.
module uart_fifo_tx #(
  parameter int bitWidth     = 8,
  parameter int cyclesPerBit = 434
) (
  input  logic           clock,
  input  logic           reset,
  uart_fifo_tx_if.master fifo,
  output logic           txd,
  output logic           busy
);

  // Counter widths: the baud counter only ever holds cyclesPerBit-1 .. 0,
  // the bit index is one bit wider than needed so it can reach bitWidth.
  localparam int CntW = (cyclesPerBit > 1) ? $clog2(cyclesPerBit) : 1;
  localparam int IdxW = $clog2(bitWidth) + 1;

  localparam logic [CntW-1:0] CntReload = CntW'(cyclesPerBit - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [IdxW-1:0] IdxOne    = IdxW'(1);
  localparam logic [IdxW-1:0] LastBit   = IdxW'(bitWidth - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_STOP   = 3'd5,
    S_PARITY = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;
`endif

  state_t              state_q,  state_d;
  logic [bitWidth-1:0] shift_q,  shift_d;
  logic [IdxW-1:0]     idx_q,    idx_d;
  logic [CntW-1:0]     cnt_q,    cnt_d;
  logic                txd_q,    txd_d;
  logic                pop_q,    pop_d;
  logic                busy_q,   busy_d;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // The current serial bit ends on the cycle the baud counter hits zero.
  logic bit_done;
  assign bit_done = (cnt_q == '0);

  // Next-state logic: FSM transitions, baud counter, bit index, shifter.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!fifo.fifoEmpty) begin
          state_d = S_POP;
        end
      end

      // fifoPop is high during this state; the word shows up next cycle.
      S_POP: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d  = fifo.fifoPopData;
        idx_d    = '0;
        cnt_d    = CntReload;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo.fifoPopData;
`endif
        state_d  = S_START;
      end

      S_START: begin
        if (bit_done) begin
          cnt_d   = CntReload;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          cnt_d   = CntReload;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IdxOne;
          if (idx_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          cnt_d   = CntReload;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
`endif

      // Last stop cycle: chain straight into the next pop if more data waits.
      S_STOP: begin
        if (bit_done) begin
          cnt_d   = CntReload;
          state_d = fifo.fifoEmpty ? S_IDLE : S_POP;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    txd_d  = 1'b1;
    pop_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_POP:    pop_d = 1'b1;
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      txd_q    <= 1'b1;
      pop_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      txd_q    <= txd_d;
      pop_q    <= pop_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign txd          = txd_q;
  assign busy         = busy_q;
  assign fifo.fifoPop = pop_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: two transmitters (cyclesPerBit 4 and 2) fed by small
// FIFO stubs. A frame-position model predicts txd/fifoPop/busy every cycle;
// directed tests pin the model with hand-computed literals.
module tb_uart_fifo_tx;
  localparam int BW = 8;
  localparam int NI = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT       = 11;  // start, 8 data, parity, stop
  localparam int LIT_FRAME4  = 44;
  localparam int LIT_PERIOD4 = 46;
  localparam int LIT_FRAME2  = 22;
  localparam int LIT_PERIOD2 = 24;
  localparam int LIT_S9_07   = 1;
  localparam int LIT_S9_03   = 0;
`else
  localparam int NSLOT       = 10;  // start, 8 data, stop
  localparam int LIT_FRAME4  = 40;
  localparam int LIT_PERIOD4 = 42;
  localparam int LIT_FRAME2  = 20;
  localparam int LIT_PERIOD2 = 22;
  localparam int LIT_S9_07   = 1;   // slot 9 is the stop bit here
  localparam int LIT_S9_03   = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_fifo_tx_if #(.bitWidth(BW)) bus0 ();
  uart_fifo_tx_if #(.bitWidth(BW)) bus1 ();
  logic txd0, txd1, busy0, busy1;

  uart_fifo_tx #(.bitWidth(BW), .cyclesPerBit(4)) dut0 (
    .clock(clk), .reset(reset), .fifo(bus0), .txd(txd0), .busy(busy0));
  uart_fifo_tx #(.bitWidth(BW), .cyclesPerBit(2)) dut1 (
    .clock(clk), .reset(reset), .fifo(bus1), .txd(txd1), .busy(busy1));

  // FIFO stubs: words pushed by the stimulus, popData registered on pop.
  logic [7:0] mem [NI][16];
  int         wr [NI] = '{0, 0};
  int         rd [NI] = '{0, 0};
  logic [7:0] pop_data [NI] = '{8'h00, 8'h00};
  logic       pop_o [NI];
  logic       txd_o [NI];
  logic       busy_o [NI];

  assign bus0.fifoEmpty   = (rd[0] == wr[0]);
  assign bus1.fifoEmpty   = (rd[1] == wr[1]);
  assign bus0.fifoPopData = pop_data[0];
  assign bus1.fifoPopData = pop_data[1];
  assign pop_o[0]  = bus0.fifoPop;
  assign pop_o[1]  = bus1.fifoPop;
  assign txd_o[0]  = txd0;
  assign txd_o[1]  = txd1;
  assign busy_o[0] = busy0;
  assign busy_o[1] = busy1;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (pop_o[i] === 1'b1 && rd[i] != wr[i]) begin
        pop_data[i] <= mem[i][rd[i] % 16];
        rd[i]       <= rd[i] + 1;
      end
    end
  end

  function automatic int cpb_of(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int frame_of(int i);
    return NSLOT * cpb_of(i);
  endfunction

  // Model: mk is the position within pop/load/frame (-1 = idle).
  // 0 = pop cycle, 1 = load cycle, 2..frame+1 = the serial frame.
  int         mk [NI]  = '{-1, -1};
  int         mrd [NI] = '{0, 0};
  logic [7:0] mword [NI] = '{8'h00, 8'h00};

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        mk[i] <= -1;
      end else if (mk[i] == -1 || mk[i] == frame_of(i) + 1) begin
        if (rd[i] != wr[i]) begin
          mk[i]    <= 0;
          mword[i] <= mem[i][mrd[i] % 16];
          mrd[i]   <= mrd[i] + 1;
        end else begin
          mk[i] <= -1;
        end
      end else begin
        mk[i] <= mk[i] + 1;
      end
    end
  end

  function automatic logic exp_txd(int i);
    int k;
    int b;
    k = mk[i];
    if (k < 2) return 1'b1;
    b = (k - 2) / cpb_of(i);
    if (b == 0) return 1'b0;
    if (b <= BW) return mword[i][b-1];
`ifdef UART_TX_PARITY_EN
    if (b == BW + 1) return ^mword[i];
`endif
    return 1'b1;
  endfunction

  // Counters and monitor state (all written from the main process only).
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   chk_en  = 1'b0;
  int   pop_cnt [NI]   = '{0, 0};
  int   last_pop [NI]  = '{0, 0};
  int   pop_gap [NI]   = '{0, 0};
  int   fall_at [NI]   = '{0, 0};
  int   fall_cnt [NI]  = '{0, 0};
  int   fall_gap [NI]  = '{0, 0};
  int   pop2fall [NI]  = '{0, 0};
  int   busy_fall [NI] = '{0, 0};
  bit   in_frame [NI]  = '{1'b0, 1'b0};
  bit   busy_prev [NI] = '{1'b0, 1'b0};
  logic slots [NI][11];
  logic [7:0] cap_byte [NI][16];
  logic cap_start [NI][16];
  logic cap_s9 [NI][16];
  logic cap_stop [NI][16];
  int   ncap [NI] = '{0, 0};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: model comparison plus frame monitor, at the falling edge.
  task automatic tick();
    int off;
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (chk_en) begin
        check($sformatf("model_txd%0d@%0d", i, cyc), {31'b0, txd_o[i]}, {31'b0, exp_txd(i)});
        check($sformatf("model_pop%0d@%0d", i, cyc), {31'b0, pop_o[i]}, {31'b0, (mk[i] == 0)});
        check($sformatf("model_busy%0d@%0d", i, cyc), {31'b0, busy_o[i]}, {31'b0, (mk[i] >= 0)});
      end
      if (pop_o[i] === 1'b1) begin
        if (pop_cnt[i] > 0) pop_gap[i] = cyc - last_pop[i];
        last_pop[i] = cyc;
        pop_cnt[i]++;
      end
      if (busy_o[i] !== 1'b1) begin
        in_frame[i] = 1'b0;
      end else if (!in_frame[i] && txd_o[i] === 1'b0) begin
        in_frame[i] = 1'b1;
        if (fall_cnt[i] > 0) fall_gap[i] = cyc - fall_at[i];
        fall_at[i]  = cyc;
        fall_cnt[i]++;
        pop2fall[i] = cyc - last_pop[i];
      end
      if (in_frame[i]) begin
        off = cyc - fall_at[i];
        if ((off % cpb_of(i)) == cpb_of(i) / 2 && (off / cpb_of(i)) < NSLOT)
          slots[i][off / cpb_of(i)] = txd_o[i];
        if (off == frame_of(i) - 1) begin
          for (int j = 0; j < 8; j++) b[j] = slots[i][j+1];
          cap_byte[i][ncap[i] % 16]  = b;
          cap_start[i][ncap[i] % 16] = slots[i][0];
          cap_s9[i][ncap[i] % 16]    = slots[i][9];
          cap_stop[i][ncap[i] % 16]  = slots[i][NSLOT-1];
          ncap[i]++;
          in_frame[i] = 1'b0;
        end
      end
      if (busy_prev[i] && busy_o[i] === 1'b0) busy_fall[i] = cyc;
      busy_prev[i] = (busy_o[i] === 1'b1);
    end
  endtask

  task automatic push(int i, logic [7:0] d);
    mem[i][wr[i] % 16] = d;
    wr[i] = wr[i] + 1;
  endtask

  // Run until instance i is idle with its FIFO drained, bounded by budget.
  task automatic wait_done(int i, int budget, string name);
    int n;
    n = 0;
    repeat (2) tick();
    while ((busy_o[i] !== 1'b0 || rd[i] != wr[i]) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_in_budget"}, (n < budget), 1);
  endtask

  int base;
  int c0;
  int pc;
  int fc;
  int n;

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    reset  = 1'b0;

    // Idle with empty FIFO: no pops, line high, not busy.
    repeat (20) tick();
    check("idle_pops0", pop_cnt[0], 0);
    check("idle_pops1", pop_cnt[1], 0);
    check("idle_txd0", {31'b0, txd0}, 1);
    check("idle_busy0", {31'b0, busy0}, 0);
    $display("[TB] idle: pops=%0d/%0d txd0=%b busy0=%b", pop_cnt[0], pop_cnt[1], txd0, busy0);

    // Single word 0xA5.
    base = pop_cnt[0]; c0 = ncap[0]; pc = cyc;
    push(0, 8'hA5);
    wait_done(0, 200, "a5");
    check("a5_pops", pop_cnt[0] - base, 1);
    check("a5_pop_latency", last_pop[0] - pc, 1);
    check("a5_pop_to_start", pop2fall[0], 2);
    check("a5_frame_len", busy_fall[0] - fall_at[0], LIT_FRAME4);
    check("a5_start", {31'b0, cap_start[0][c0 % 16]}, 0);
    check("a5_data", {24'b0, cap_byte[0][c0 % 16]}, 32'hA5);
    check("a5_stop", {31'b0, cap_stop[0][c0 % 16]}, 1);
    $display("[TB] word a5: data=%h frame=%0d", cap_byte[0][c0 % 16], busy_fall[0] - fall_at[0]);

    // Back-to-back 0x00, 0xFF.
    base = pop_cnt[0]; c0 = ncap[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_done(0, 300, "b2b");
    check("b2b_pops", pop_cnt[0] - base, 2);
    check("b2b_pop_spacing", pop_gap[0], LIT_PERIOD4);
    check("b2b_start_spacing", fall_gap[0], LIT_PERIOD4);
    check("b2b_data0", {24'b0, cap_byte[0][c0 % 16]}, 32'h00);
    check("b2b_data1", {24'b0, cap_byte[0][(c0 + 1) % 16]}, 32'hFF);
    $display("[TB] words 00,ff: pops=%0d spacing=%0d", pop_cnt[0] - base, fall_gap[0]);

    // 0x07 then 0x03: slot 9 is parity (parity build) or stop.
    c0 = ncap[0];
    push(0, 8'h07);
    push(0, 8'h03);
    wait_done(0, 300, "par");
    check("par_data07", {24'b0, cap_byte[0][c0 % 16]}, 32'h07);
    check("par_slot9_07", {31'b0, cap_s9[0][c0 % 16]}, LIT_S9_07);
    check("par_slot9_03", {31'b0, cap_s9[0][(c0 + 1) % 16]}, LIT_S9_03);
    check("par_stop_03", {31'b0, cap_stop[0][(c0 + 1) % 16]}, 1);
    check("par_frame_len", busy_fall[0] - fall_at[0], LIT_FRAME4);
    $display("[TB] words 07,03: slot9=%b,%b", cap_s9[0][c0 % 16], cap_s9[0][(c0 + 1) % 16]);

    // Reset in the middle of data bit 3 of 0x55.
    base = pop_cnt[0]; fc = fall_cnt[0];
    push(0, 8'h55);
    n = 0;
    while (fall_cnt[0] == fc && n < 50) begin tick(); n++; end
    check("rst_start_seen", (fall_cnt[0] != fc), 1);
    n = 0;
    while (cyc < fall_at[0] + 17 && n < 50) begin tick(); n++; end
    reset = 1'b1;
    tick();
    check("rst_txd", {31'b0, txd0}, 1);
    check("rst_busy", {31'b0, busy0}, 0);
    check("rst_pop", {31'b0, bus0.fifoPop}, 0);
    reset = 1'b0;
    repeat (20) tick();
    check("rst_no_more_pops", pop_cnt[0] - base, 1);
    check("rst_idle_txd", {31'b0, txd0}, 1);
    $display("[TB] reset mid-frame: pops=%0d txd0=%b busy0=%b", pop_cnt[0] - base, txd0, busy0);

    // cyclesPerBit=2, three queued words.
    base = pop_cnt[1]; c0 = ncap[1];
    push(1, 8'h12);
    push(1, 8'h34);
    push(1, 8'h56);
    wait_done(1, 300, "cpb2");
    check("cpb2_pops", pop_cnt[1] - base, 3);
    check("cpb2_pop_spacing", pop_gap[1], LIT_PERIOD2);
    check("cpb2_start_spacing", fall_gap[1], LIT_PERIOD2);
    check("cpb2_frame_len", busy_fall[1] - fall_at[1], LIT_FRAME2);
    check("cpb2_data0", {24'b0, cap_byte[1][c0 % 16]}, 32'h12);
    check("cpb2_data1", {24'b0, cap_byte[1][(c0 + 1) % 16]}, 32'h34);
    check("cpb2_data2", {24'b0, cap_byte[1][(c0 + 2) % 16]}, 32'h56);
    $display("[TB] cpb2 x3: pops=%0d pop_spacing=%0d frame=%0d", pop_cnt[1] - base, pop_gap[1],
             busy_fall[1] - fall_at[1]);

    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Serial transmitter that drains bytes from the pop side of a `fifo` instance and sends each one as an asynchronous UART frame on a single output line. It sits between the system-side FIFO (written by the processor or DMA through `push`/`pushData`) and the board-level TX pin. It is the consuming end of the FIFO interface: it owns `pop` and observes `empty`/`popData`.

## Interface
- `bitWidth`, 8: data bits per frame; must match the FIFO's `bitWidth`.
- `cyclesPerBit`, 434: clock cycles per serial bit (50 MHz / 115200 baud); legal range 2 to 65535.
- `clock`  input  1  single system clock, all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `fifoEmpty`  input  1  `empty` output of the source FIFO.
- `fifoPopData`  input  bitWidth  `popData` output of the source FIFO; valid the cycle after `fifoPop` is high.
- `fifoPop`  output  1  `pop` input of the source FIFO; high for exactly one cycle per word.
- `txd`  output  1  serial line; idle high.
- `busy`  output  1  high from the pop cycle through the last cycle of the stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `txd`=1, `busy`=0. If `fifoEmpty`=0, go to POP; otherwise stay.
- POP: `fifoPop`=1 for this cycle only; go to LOAD.
- LOAD: capture `fifoPopData` into the shift register; clear the bit index; load the baud counter with `cyclesPerBit`-1; go to START.
- START: `txd`=0 for `cyclesPerBit` cycles, then go to DATA.
- DATA: `txd` = shift register bit 0, LSB first. Each bit lasts `cyclesPerBit` cycles, then the register shifts right. After bit `bitWidth`-1, go to PARITY if compiled in, otherwise to STOP.
- STOP: `txd`=1 for `cyclesPerBit` cycles. On the last cycle, sample `fifoEmpty`: if 0, go to POP; otherwise go to IDLE.
- Baud counter: $clog2(cyclesPerBit) bits wide. It counts down, and the bit ends when it reaches 0, at which point it reloads `cyclesPerBit`-1.
- Bit index: $clog2(bitWidth)+1 bits wide, so counting to `bitWidth` never wraps.
- `fifoPop` and `txd` are decoded from registered state only. There is no combinational path from `fifoEmpty` or `fifoPopData` to any output.
- The block never pops while `fifoEmpty`=1. `fifoEmpty` is sampled only in IDLE and on the last STOP cycle.
- Reset in any state: the next state is IDLE, `txd`=1, `fifoPop`=0, `busy`=0. A frame in progress is abandoned, and a word already popped is discarded.
- Reset values: `txd`=1, `fifoPop`=0, `busy`=0, shift register 0, counters 0.

## Timing
- Latency: `fifoEmpty` is seen low in IDLE in cycle t. `fifoPop`=1 in t+1, capture happens in t+2, and the `txd` falling edge occurs at the start of t+3.
- Frame length (no parity): (`bitWidth`+2)×`cyclesPerBit` cycles.
- Back-to-back frames: `txd` stays high for 2 extra cycles (POP + LOAD) between a stop bit and the next start bit.
- Throughput: one word per (`bitWidth`+2)×`cyclesPerBit`+2 cycles while the FIFO is non-empty.
- `busy` rises in the POP cycle and falls on the first IDLE cycle.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is inserted after DATA. `txd` carries even parity (XOR of all data bits) for `cyclesPerBit` cycles, and the frame becomes (`bitWidth`+3)×`cyclesPerBit` cycles.
- `UART_TX_PARITY_EN` undefined: there is no PARITY state or parity logic, and DATA goes directly to STOP.

## Test plan
- Reset with `fifoEmpty`=1 held for 20 cycles (`cyclesPerBit`=4) -> `txd`=1, `fifoPop`=0 and `busy`=0 throughout.
- Single word 0xA5, `cyclesPerBit`=4, `fifoEmpty` goes to 0 and returns to 1 after the pop -> `fifoPop` pulses once at t+1. `txd` carries start 0, then 1,0,1,0,0,1,0,1 (4 cycles each), then stop 1. The frame is 40 cycles, and `busy` falls after the stop bit.
- Words 0x00 then 0xFF queued -> exactly two pops. The idle-high gap between the first stop bit and the second start bit is 2 cycles.
- Parity build, word 0x07 -> parity bit 1 after the data bits. Word 0x03 -> parity bit 0. The frame is 44 cycles.
- `reset` asserted in the middle of bit 3 of 0x55 -> `txd`=1 on the next cycle and the state is IDLE. With `fifoEmpty`=1 there is no further pop.
- `cyclesPerBit`=2 with the FIFO kept non-empty for 3 words -> each frame is exactly 20 cycles, and pops are 22 cycles apart.
